// File: rtl/pong_pkg.sv
// Shared types and default geometry for the Pong game engine and the VGA monitor.
package pong_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam int DEF_TICK_DIV    = 833333;
  localparam int DEF_BALL_SIZE   = 8;
  localparam int DEF_PADDLE_H    = 64;
  localparam int DEF_PADDLE_W    = 8;
  localparam int DEF_PADDLE_X_E  = 16;
  localparam int DEF_PADDLE_X_D  = 616;
  localparam int DEF_BALL_STEP   = 2;
  localparam int DEF_PADDLE_STEP = 4;
  localparam int DEF_SERVE_TICKS = 60;
  localparam int DEF_MAX_SCORE   = 9;
  localparam int NUM_PADDLES     = 2;

  typedef enum logic [1:0] {SERVE, PLAY, GAME_OVER} state_t;
  typedef logic signed [10:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    logic   dx_neg;
    logic   dy_neg;
  } ball_t;

  // Vertical overlap between the ball and a paddle spanning [pad_y, pad_y+height).
  function automatic logic overlaps(input coord_t ball_y, input coord_t pad_y,
                                    input coord_t size, input coord_t height);
    return (ball_y + size > pad_y) && (ball_y < pad_y + height);
  endfunction
endpackage

// File: rtl/pong_tick_gen.sv
// Free-running divider: one-cycle game tick every TICK_DIV clocks.
module pong_tick_gen #(
  parameter int TICK_DIV = 833333
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/pong_engine.sv
// Pong game logic: button sync, paddles, ball physics, scoring and serve/play/game-over flow.
module pong_engine
  import pong_pkg::*;
#(
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int BALL_SIZE   = DEF_BALL_SIZE,
  parameter int PADDLE_H    = DEF_PADDLE_H,
  parameter int PADDLE_W    = DEF_PADDLE_W,
  parameter int PADDLE_X_E  = DEF_PADDLE_X_E,
  parameter int PADDLE_X_D  = DEF_PADDLE_X_D,
  parameter int BALL_STEP   = DEF_BALL_STEP,
  parameter int PADDLE_STEP = DEF_PADDLE_STEP,
  parameter int SERVE_TICKS = DEF_SERVE_TICKS,
  parameter int MAX_SCORE   = DEF_MAX_SCORE
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [3:0] buttons_export,
  output logic [9:0] bola_x,
  output logic [9:0] bola_y,
  output logic [9:0] barra_e_y,
  output logic [9:0] barra_d_y,
  output logic [3:0] score_e,
  output logic [3:0] score_d,
  output logic       point_e,
  output logic       point_d,
  output logic       game_over,
  output logic       tick
);
  localparam coord_t BS        = coord_t'(BALL_SIZE);
  localparam coord_t PH        = coord_t'(PADDLE_H);
  localparam coord_t BSTEP     = coord_t'(BALL_STEP);
  localparam coord_t PSTEP     = coord_t'(PADDLE_STEP);
  localparam coord_t HA        = coord_t'(H_ACTIVE);
  localparam coord_t VA        = coord_t'(V_ACTIVE);
  localparam coord_t X_HIT_E   = coord_t'(PADDLE_X_E + PADDLE_W);
  localparam coord_t XD        = coord_t'(PADDLE_X_D);
  localparam coord_t BALL_X0   = coord_t'((H_ACTIVE - BALL_SIZE) / 2);
  localparam coord_t BALL_Y0   = coord_t'((V_ACTIVE - BALL_SIZE) / 2);
  localparam coord_t PAD_Y0    = coord_t'((V_ACTIVE - PADDLE_H) / 2);
  localparam coord_t PAD_MAX   = coord_t'(V_ACTIVE - PADDLE_H);
  localparam coord_t BALL_YMAX = coord_t'(V_ACTIVE - BALL_SIZE);
  localparam int     SCW       = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
  localparam logic [SCW-1:0] SERVE_LAST = SCW'(SERVE_TICKS - 1);
  localparam logic [3:0]     MAX_S      = 4'(MAX_SCORE);

  state_t                   state, state_nxt;
  ball_t                    ball, ball_nxt;
  coord_t [NUM_PADDLES-1:0] pad, pad_mv, pad_nxt;
  logic [SCW-1:0]           serve_cnt, serve_cnt_nxt;
  logic [3:0]               score_e_nxt, score_d_nxt;
  logic                     point_e_nxt, point_d_nxt;
  logic [3:0]               sync0, sync1, btn_prev, pressed;
  logic                     key_fall, restart_pend, restart_req;
  logic                     hit_e, hit_d, goal_l, goal_r;

  pong_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .tick  (tick)
  );

  // Keys are active-low; a restart press seen between ticks is held until the next tick.
  assign pressed     = ~sync1;
  assign key_fall    = |(btn_prev & ~sync1);
  assign restart_req = restart_pend | key_fall;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync0        <= '1;
      sync1        <= '1;
      btn_prev     <= '1;
      restart_pend <= 1'b0;
    end else begin
      sync0        <= buttons_export;
      sync1        <= sync0;
      btn_prev     <= sync1;
      restart_pend <= (state == GAME_OVER) && !tick && restart_req;
    end
  end

  for (genvar p = 0; p < NUM_PADDLES; p++) begin : g_pad
    logic up, dn;
    assign up = pressed[2*p];
    assign dn = pressed[2*p+1];
    assign pad_mv[p] = (up && !dn) ? ((pad[p] < PSTEP) ? coord_t'(0) : pad[p] - PSTEP)
                     : (dn && !up) ? ((pad[p] > PAD_MAX - PSTEP) ? PAD_MAX : pad[p] + PSTEP)
                     : pad[p];
  end

  // Collision tests use the paddle positions before this tick's move.
  assign hit_e  = ball.dx_neg && (ball.x >= X_HIT_E) && (ball.x - BSTEP <= X_HIT_E)
                  && overlaps(ball.y, pad[0], BS, PH);
  assign hit_d  = !ball.dx_neg && (ball.x + BS <= XD) && (ball.x + BS + BSTEP >= XD)
                  && overlaps(ball.y, pad[1], BS, PH);
  assign goal_l = ball.dx_neg && (ball.x < BSTEP) && !hit_e;
  assign goal_r = !ball.dx_neg && (ball.x + BS + BSTEP > HA) && !hit_d;

  always_comb begin
    state_nxt     = state;
    ball_nxt      = ball;
    pad_nxt       = pad_mv;
    serve_cnt_nxt = serve_cnt;
    score_e_nxt   = score_e;
    score_d_nxt   = score_d;
    point_e_nxt   = 1'b0;
    point_d_nxt   = 1'b0;
    case (state)
      SERVE: begin
        ball_nxt.x = BALL_X0;
        ball_nxt.y = BALL_Y0;
        if (serve_cnt == SERVE_LAST) begin
          state_nxt     = PLAY;
          serve_cnt_nxt = '0;
        end else begin
          serve_cnt_nxt = serve_cnt + 1'b1;
        end
      end
      PLAY: begin
        if (hit_e) begin
          ball_nxt.x      = X_HIT_E;
          ball_nxt.dx_neg = 1'b0;
        end else if (hit_d) begin
          ball_nxt.x      = XD - BS;
          ball_nxt.dx_neg = 1'b1;
        end else begin
          ball_nxt.x = ball.dx_neg ? ball.x - BSTEP : ball.x + BSTEP;
        end
        if (ball.dy_neg && (ball.y < BSTEP)) begin
          ball_nxt.y      = '0;
          ball_nxt.dy_neg = 1'b0;
        end else if (!ball.dy_neg && (ball.y + BS + BSTEP > VA)) begin
          ball_nxt.y      = BALL_YMAX;
          ball_nxt.dy_neg = 1'b1;
        end else begin
          ball_nxt.y = ball.dy_neg ? ball.y - BSTEP : ball.y + BSTEP;
        end
        if (goal_l || goal_r) begin
          ball_nxt.x      = BALL_X0;
          ball_nxt.y      = BALL_Y0;
          ball_nxt.dx_neg = goal_l;  // next serve heads toward the side that conceded
          ball_nxt.dy_neg = 1'b0;
          serve_cnt_nxt   = '0;
          if (goal_l) begin
            score_d_nxt = score_d + 1'b1;
            point_d_nxt = 1'b1;
          end else begin
            score_e_nxt = score_e + 1'b1;
            point_e_nxt = 1'b1;
          end
          state_nxt = (score_e_nxt == MAX_S || score_d_nxt == MAX_S) ? GAME_OVER : SERVE;
        end
      end
      GAME_OVER: begin
        ball_nxt.x = BALL_X0;
        ball_nxt.y = BALL_Y0;
        pad_nxt    = pad;
        if (restart_req) begin
          score_e_nxt     = '0;
          score_d_nxt     = '0;
          pad_nxt         = {NUM_PADDLES{PAD_Y0}};
          ball_nxt.dx_neg = 1'b0;
          ball_nxt.dy_neg = 1'b0;
          serve_cnt_nxt   = '0;
          state_nxt       = SERVE;
        end
      end
      default: state_nxt = SERVE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state     <= SERVE;
      ball      <= '{x: BALL_X0, y: BALL_Y0, dx_neg: 1'b0, dy_neg: 1'b0};
      pad       <= {NUM_PADDLES{PAD_Y0}};
      serve_cnt <= '0;
      score_e   <= '0;
      score_d   <= '0;
      point_e   <= 1'b0;
      point_d   <= 1'b0;
    end else begin
      point_e <= tick & point_e_nxt;
      point_d <= tick & point_d_nxt;
      if (tick) begin
        state     <= state_nxt;
        ball      <= ball_nxt;
        pad       <= pad_nxt;
        serve_cnt <= serve_cnt_nxt;
        score_e   <= score_e_nxt;
        score_d   <= score_d_nxt;
      end
    end
  end

  assign bola_x    = ball.x[9:0];
  assign bola_y    = ball.y[9:0];
  assign barra_e_y = pad[0][9:0];
  assign barra_d_y = pad[1][9:0];
  assign game_over = (state == GAME_OVER);
endmodule

// File: tb/tb_pong_engine.sv
// Randomized bench for pong_engine against a tick-level integer model of the game rules.
module tb_pong_engine;
  localparam int TD = 4;
  localparam int ST = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] buttons = 4'hF;
  logic [9:0] bola_x, bola_y, barra_e_y, barra_d_y;
  logic [3:0] score_e, score_d;
  logic       point_e, point_d, game_over, tick;

  int n_tests = 0;
  int n_fail  = 0;

  pong_engine #(.TICK_DIV(TD), .SERVE_TICKS(ST)) dut (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .buttons_export (buttons),
    .bola_x         (bola_x),
    .bola_y         (bola_y),
    .barra_e_y      (barra_e_y),
    .barra_d_y      (barra_d_y),
    .score_e        (score_e),
    .score_d        (score_d),
    .point_e        (point_e),
    .point_d        (point_d),
    .game_over      (game_over),
    .tick           (tick)
  );

  always #5 clk = ~clk;

  // Model: phase 0 = serving, 1 = in play, 2 = game over; directions are +1/-1.
  int         mx, my, mdx, mdy, mse, msd, mcnt, mphase, mpe, mpd;
  int         mpad[2];
  logic [3:0] btn_cur, btn_old, nb;
  int         hits = 0, goals = 0, overs = 0, restarts = 0, post = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mx = 316; my = 236; mdx = 1; mdy = 1;
    mse = 0; msd = 0; mcnt = 0; mphase = 0; mpe = 0; mpd = 0;
    mpad[0] = 208; mpad[1] = 208;
    btn_cur = 4'hF; btn_old = 4'hF;
  endtask

  task automatic recentre(input int score, input int dir);
    mx = 316; my = 236; mdx = dir; mdy = 1; mcnt = 0;
    if (score == 9) begin mphase = 2; overs++; end
    else mphase = 0;
  endtask

  task automatic model_tick();
    int  op0, op1;
    bit  hl, hr;
    mpe = 0; mpd = 0;
    if (mphase == 2) begin
      if ((btn_old & ~btn_cur) != 4'h0) begin
        mse = 0; msd = 0; mpad[0] = 208; mpad[1] = 208;
        mphase = 0; mcnt = 0; mdx = 1; mdy = 1; restarts++;
      end
      return;
    end
    op0 = mpad[0]; op1 = mpad[1];
    for (int p = 0; p < 2; p++) begin
      bit up = !btn_cur[2*p];
      bit dn = !btn_cur[2*p+1];
      if (up && !dn)      mpad[p] = (mpad[p] - 4 < 0) ? 0 : mpad[p] - 4;
      else if (dn && !up) mpad[p] = (mpad[p] + 4 > 416) ? 416 : mpad[p] + 4;
    end
    if (mphase == 0) begin
      mcnt++;
      if (mcnt == ST) begin mphase = 1; mcnt = 0; end
      return;
    end
    hl = (mdx < 0) && (mx >= 24) && (mx - 2 <= 24) && (my + 8 > op0) && (my < op0 + 64);
    hr = (mdx > 0) && (mx + 8 <= 616) && (mx + 10 >= 616) && (my + 8 > op1) && (my < op1 + 64);
    if ((mdx < 0) && (mx < 2) && !hl) begin
      msd++; mpd = 1; goals++; recentre(msd, -1);
    end else if ((mdx > 0) && (mx + 10 > 640) && !hr) begin
      mse++; mpe = 1; goals++; recentre(mse, 1);
    end else begin
      if (hl)      begin mx = 24;  mdx = 1;  hits++; end
      else if (hr) begin mx = 608; mdx = -1; hits++; end
      else mx += 2 * mdx;
      if ((mdy < 0) && (my < 2))              begin my = 0;   mdy = 1;  end
      else if ((mdy > 0) && (my + 10 > 480))  begin my = 472; mdy = -1; end
      else my += 2 * mdy;
    end
  endtask

  // Paddle AI: returns {down_n, up_n} steering the paddle centre to the ball.
  function automatic logic [1:0] track(input int pad_y, input int ball_y);
    if (pad_y + 32 > ball_y + 6) return 2'b10;
    if (pad_y + 32 < ball_y + 2) return 2'b01;
    return 2'b11;
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_bola_x"}, bola_x, 316);
    chk({tag, "_bola_y"}, bola_y, 236);
    chk({tag, "_barra_e"}, barra_e_y, 208);
    chk({tag, "_barra_d"}, barra_d_y, 208);
    chk({tag, "_score_e"}, score_e, 0);
    chk({tag, "_score_d"}, score_d, 0);
    chk({tag, "_point"}, {point_e, point_d}, 0);
    chk({tag, "_game_over"}, game_over, 0);
    chk({tag, "_tick"}, tick, 0);
  endtask

  // Called at the negedge of release; leaves us at the negedge where the first tick is high.
  task automatic after_release();
    @(negedge clk); chk("tick_c1", tick, 0);
    @(negedge clk); chk("tick_c2", tick, 0);
    @(negedge clk);
  endtask

  // One game tick: entered at a negedge with tick expected high, exits at the next such negedge.
  task automatic step(input logic [3:0] next_btn);
    chk("tick_due", tick, 1);
    model_tick();
    @(posedge clk);
    @(negedge clk);
    chk("bola_x", bola_x, mx);
    chk("bola_y", bola_y, my);
    chk("barra_e_y", barra_e_y, mpad[0]);
    chk("barra_d_y", barra_d_y, mpad[1]);
    chk("score_e", score_e, mse);
    chk("score_d", score_d, msd);
    chk("point_e", point_e, mpe);
    chk("point_d", point_d, mpd);
    chk("game_over", game_over, mphase == 2);
    chk("tick_low", tick, 0);
    btn_old = btn_cur; btn_cur = next_btn; buttons = next_btn;
    @(negedge clk);
    chk("point_pulse_end", {point_e, point_d}, 0);
    repeat (TD - 2) @(negedge clk);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    rst_n = 1'b1;
    after_release();

    // Left paddle up into the floor, right paddle down into the cap.
    for (int t = 0; t < 60; t++) step(4'b0110);
    chk("pad_e_floor", barra_e_y, 0);
    chk("pad_d_cap", barra_d_y, 416);
    // Both left keys together: hold.
    for (int t = 0; t < 10; t++) step(4'b1100);
    chk("pad_e_both_hold", barra_e_y, 0);

    // Rallies: both paddles track for a while, then the left one wanders randomly.
    for (int t = 0; t < 6000; t++) begin
      if (t < 300) nb = {track(mpad[1], my), track(mpad[0], my)};
      else         nb = {track(mpad[1], my), 2'($urandom_range(0, 3))};
      step(nb);
      if (restarts > 0) post++;
      if (post > 80) break;
    end
    $display("[TB] info: hits=%0d goals=%0d game_overs=%0d restarts=%0d", hits, goals, overs, restarts);

    // Asynchronous reset in the middle of a game, between clock edges.
    #2 rst_n = 1'b0; buttons = 4'hF;
    #1 check_reset_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    after_release();
    for (int t = 0; t < 30; t++) step(4'($urandom_range(0, 15)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
